i2c_target: RTL and testbench
=============================

// Module: i2c_target
// PURPOSE
//  I2C responder (target) end of the bus driven by the team's I2C_driver initiator.
//  Oversamples SCL/SDA on the system clock, detects START/STOP and matches a 7-bit address.
//  Delivers written bytes to local logic and serves read bytes from local logic.
//  SDA is open-drain via an output-enable; the pad ties SDA low when sda_oe=1.
// PARAMETERS
//  TARGET_ADDR  7'h42  7-bit address this target answers to
//  SYNC_STAGES  2      synchroniser depth on scl_in/sda_in (>=2)
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  rst        in   1  synchronous, active-high reset
//  scl_in     in   1  I2C SCL pad input (asynchronous)
//  sda_in     in   1  I2C SDA pad input (asynchronous)
//  sda_oe     out  1  1 = pull SDA low, 0 = release
//  scl_oe     out  1  1 = hold SCL low (stretch); tied 0 without I2C_CLK_STRETCH_EN
//  wr_valid   out  1  one-cycle pulse: wr_data holds a received write byte
//  wr_data    out  8  received byte, stable until next wr_valid
//  rd_req     out  1  one-cycle pulse: target needs the next read byte
//  tx_data    in   8  byte to return to initiator
//  tx_valid   in   1  tx_data valid (used only with I2C_CLK_STRETCH_EN)
//  busy       out  1  high from address match until STOP / repeated START
// BEHAVIOUR
//  Reset: sda_oe=0, scl_oe=0, wr_valid=0, wr_data=8'h00, rd_req=0, busy=0, state=IDLE.
//  Input path: SYNC_STAGES flops plus one history flop; scl_rise/scl_fall/sda_rise/sda_fall are 1-cycle pulses.
//  START = sda_fall while SCL high; STOP = sda_rise while SCL high; both override every state.
//  Data is sampled on scl_rise; sda_oe changes only on the cycle after scl_fall.
//  States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
//  IDLE    -> ADDR on START; bit counter cleared.
//  ADDR    shift 8 bits MSB first ({addr,rw}); after 8th scl_rise:
//          match -> ADDR_ACK, busy=1; mismatch -> IGNORE (SDA never driven).
//  ADDR_ACK  sda_oe=1 from 8th scl_fall until 9th scl_fall.
//          rw=0 -> WR_BYTE; rw=1 -> rd_req pulse at 8th scl_fall, then RD_BYTE.
//  WR_BYTE on 8th scl_rise: wr_data<=byte, wr_valid=1 for one cycle -> WR_ACK.
//  WR_ACK  always ACK (sda_oe=1 for the 9th bit) -> WR_BYTE.
//  RD_BYTE tx_data latched into shifter on the rd_req cycle; sda_oe=~shift[7] after each scl_fall.
//          After 8 bits, release SDA -> RD_ACK.
//  RD_ACK  sample SDA on 9th scl_rise: 0 (ACK) -> rd_req pulse, next RD_BYTE.
//          1 (NACK) -> IGNORE, SDA released.
//  IGNORE  never drives; leaves only on START (-> ADDR) or STOP (-> IDLE).
//  START mid-byte (repeated START): drop partial byte, no wr_valid, busy=0, -> ADDR.
//  STOP anywhere: release sda_oe/scl_oe within 1 cycle, busy=0, -> IDLE.
//  General-call address 7'h00 is not matched; bit counter is 4 bits and saturates at 9.
//  Latency: wr_valid 1 cycle after the synchronised 8th SCL rise.
// CONFIGURATION
//  I2C_CLK_STRETCH_EN defined:
//  - After rd_req, if tx_valid=0, scl_oe=1 (hold SCL low) from the next scl_fall.
//  - Shifter loads tx_data on the first cycle tx_valid=1; scl_oe drops the cycle after.
//  - STOP/START clears the stretch.
//  I2C_CLK_STRETCH_EN undefined:
//  - scl_oe tied 0; tx_valid ignored; tx_data sampled on the rd_req cycle.
// TESTING
//  1. Write 0x84 (addr 0x42,W), 0xA5, STOP -> addr ACKed; wr_valid once, wr_data=8'hA5; busy 1->0.
//  2. Address 0x43 write, 0x11 -> sda_oe stays 0 throughout; no wr_valid; busy=0.
//  3. Read 0x85, tx_data=8'h3C, initiator ACK, then tx_data=8'hC3, initiator NACK, STOP
//     -> SDA bits 00111100 then 11000011; two rd_req pulses; release after NACK.
//  4. Write 0x84, 4 bits of 0xF0, repeated START, 0x85 read -> no wr_valid; read phase served.
//  5. rst asserted mid-RD_BYTE with sda_oe=1 -> next cycle sda_oe=0, busy=0, state IDLE.
//  6. (I2C_CLK_STRETCH_EN) read with tx_valid low 50 clk after rd_req
//     -> scl_oe=1 until tx_valid; correct byte shifted.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match, byte write/read.
// Optional clock stretching on reads while local data is not ready: define I2C_CLK_STRETCH_EN.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic       wr_valid,
  output logic [7:0] wr_data,
  output logic       rd_req,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_BYTE  = 3'd3,
    WR_ACK   = 3'd4,
    RD_BYTE  = 3'd5,
    RD_ACK   = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  // Synchronisers reset to the idle-bus level so reset release creates no false edges.
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, sda_rise, sda_fall;
  logic                   start_det, stop_det;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign sda_rise  = sda_s & ~sda_hist_q;
  assign sda_fall  = ~sda_s & sda_hist_q;
  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0] rx_q, rx_d, tx_q, tx_d, byte_in;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic       wr_valid_q, wr_valid_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rd_req_q, rd_req_d;
  logic       busy_q, busy_d;
  logic       begin_rd;

`ifdef I2C_CLK_STRETCH_EN
  logic       pend_q, pend_d;
  logic       scl_oe_q, scl_oe_d;
  logic       tx_rdy;
  logic [7:0] tx_cur;
  // A pending byte that arrives on the very edge it is needed is used directly.
  assign tx_rdy = ~pend_q | tx_valid;
  assign tx_cur = pend_q ? tx_data : tx_q;
`else
  logic [7:0] tx_cur;
  logic       unused_tx_valid;
  assign tx_cur          = tx_q;
  assign unused_tx_valid = tx_valid;
`endif

  assign byte_in = {rx_q[6:0], sda_s};
  assign cnt_inc = (cnt_q == 4'd9) ? 4'd9 : cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    wr_valid_d = 1'b0;
    wr_data_d  = wr_data_q;
    rd_req_d   = 1'b0;
    busy_d     = busy_q;
    begin_rd   = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
    pend_d     = pend_q;
    scl_oe_d   = scl_oe_q;
    if (rd_req_q) begin
      if (tx_valid) tx_d = tx_data;
      else          pend_d = 1'b1;
    end else if (pend_q && tx_valid) begin
      pend_d   = 1'b0;
      scl_oe_d = 1'b0;
      tx_d     = tx_data;
      // Already stretching: the first bit was never put out, present it now.
      if (scl_oe_q) begin
        tx_d     = {tx_data[6:0], 1'b0};
        sda_oe_d = ~tx_data[7];
      end
    end
`else
    if (rd_req_q) tx_d = tx_data;
`endif

    case (state_q)
      ADDR: begin
        if (scl_rise) begin
          rx_d  = byte_in;
          cnt_d = cnt_inc;
          if (cnt_q == 4'd7) begin
            rw_d = sda_s;
            if (rx_q[6:0] == TARGET_ADDR && TARGET_ADDR != 7'h00) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
      end
      ADDR_ACK, WR_ACK: begin
        if (scl_rise) cnt_d = cnt_inc;
        if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            if (state_q == ADDR_ACK && rw_q) rd_req_d = 1'b1;
          end else if (cnt_q == 4'd9) begin
            cnt_d = 4'd0;
            if (state_q == ADDR_ACK && rw_q) begin
              begin_rd = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WR_BYTE;
            end
          end
        end
      end
      WR_BYTE: begin
        if (scl_rise) begin
          rx_d  = byte_in;
          cnt_d = cnt_inc;
          if (cnt_q == 4'd7) begin
            wr_data_d  = byte_in;
            wr_valid_d = 1'b1;
            state_d    = WR_ACK;
          end
        end
      end
      RD_BYTE: begin
        if (scl_rise) cnt_d = cnt_inc;
        if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            state_d  = RD_ACK;
          end else begin
            sda_oe_d = ~tx_q[7];
            tx_d     = {tx_q[6:0], 1'b0};
          end
        end
      end
      RD_ACK: begin
        if (scl_rise) begin
          cnt_d = cnt_inc;
          if (sda_s) state_d  = IGNORE;
          else       rd_req_d = 1'b1;
        end
        if (scl_fall && cnt_q == 4'd9) begin_rd = 1'b1;
      end
      default: ;
    endcase

    // First data bit goes out on the ACK-ending SCL fall.
    if (begin_rd) begin
      state_d = RD_BYTE;
      cnt_d   = 4'd0;
`ifdef I2C_CLK_STRETCH_EN
      if (tx_rdy) begin
        sda_oe_d = ~tx_cur[7];
        tx_d     = {tx_cur[6:0], 1'b0};
        pend_d   = 1'b0;
      end else begin
        sda_oe_d = 1'b0;
        scl_oe_d = 1'b1;
      end
`else
      sda_oe_d = ~tx_cur[7];
      tx_d     = {tx_cur[6:0], 1'b0};
`endif
    end

    if (stop_det || start_det) begin
      state_d    = stop_det ? IDLE : ADDR;
      cnt_d      = 4'd0;
      rx_d       = 8'h00;
      sda_oe_d   = 1'b0;
      wr_valid_d = 1'b0;
      rd_req_d   = 1'b0;
      busy_d     = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
      pend_d     = 1'b0;
      scl_oe_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rx_q       <= 8'h00;
      tx_q       <= 8'h00;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= 8'h00;
      rd_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      rd_req_q   <= rd_req_d;
      busy_q     <= busy_d;
    end
  end

`ifdef I2C_CLK_STRETCH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= 1'b0;
      scl_oe_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      scl_oe_q <= scl_oe_d;
    end
  end
  assign scl_oe = scl_oe_q;
`else
  assign scl_oe = 1'b0;
`endif

  assign sda_oe   = sda_oe_q;
  assign wr_valid = wr_valid_q;
  assign wr_data  = wr_data_q;
  assign rd_req   = rd_req_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged initiator with open-drain bus model and scoreboard queues.
// Stretch scenario is included when I2C_CLK_STRETCH_EN is defined.
module tb_i2c_target;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_drv, sda_drv;
  logic       scl_in, sda_in;
  logic       sda_oe, scl_oe, wr_valid, rd_req, tx_valid, busy;
  logic [7:0] wr_data, tx_data;

  int errs = 0, checks = 0;
  int wr_cnt = 0, rd_cnt = 0, tx_delay = 0;
  logic oe_seen = 1'b0, busy_seen = 1'b0, stretch_seen = 1'b0;
  logic [7:0] wr_exp_q[$], rd_exp_q[$], txq[$];

  assign scl_in = scl_drv & ~scl_oe;
  assign sda_in = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(.TARGET_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe(sda_oe), .scl_oe(scl_oe), .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_req(rd_req), .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_up();
    int n = 0;
    scl_drv = 1'b1;
    while (!scl_in && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!scl_in) chk("scl_release_timeout", scl_in, 1);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_drv = b;
    wait_clks(Q);
    scl_up();
    wait_clks(Q);
    s = sda_in;
    @(negedge clk);
    scl_drv = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1;
    wait_clks(Q);
    scl_up();
    wait_clks(Q);
    sda_drv = 1'b0;
    wait_clks(Q);
    scl_drv = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0;
    wait_clks(Q);
    scl_up();
    wait_clks(Q);
    sda_drv = 1'b1;
    wait_clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(ack_bit, s);
  endtask

  task automatic rd_check(input string tag, input logic [7:0] got);
    logic [31:0] exp;
    exp = (rd_exp_q.size() > 0) ? {24'h0, rd_exp_q.pop_front()} : 32'hxxxx_xxxx;
    chk(tag, {24'h0, got}, exp);
  endtask

  // Write-side scoreboard: every wr_valid consumes one expected byte.
  initial forever begin
    @(negedge clk);
    if (wr_valid) begin
      wr_cnt++;
      if (wr_exp_q.size() == 0) chk("wr_unexpected", wr_valid, 0);
      else chk("wr_data", wr_data, wr_exp_q.pop_front());
    end
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  // Local-logic model: supplies the next read byte on each rd_req.
  initial forever begin
    @(negedge clk);
    if (rd_req) begin
      rd_cnt++;
      if (txq.size() == 0) chk("rd_unexpected", rd_req, 0);
      else begin
        if (tx_delay > 0) begin
          tx_valid = 1'b0;
          repeat (tx_delay) begin
            @(negedge clk);
            if (scl_oe) stretch_seen = 1'b1;
          end
        end
        tx_data  = txq.pop_front();
        tx_valid = 1'b1;
        rd_exp_q.push_back(tx_data);
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a;
    logic [7:0] b;
    int         w0, r0, n;
    rst = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1; tx_data = 8'h00; tx_valid = 1'b1;
    wait_clks(4);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    wait_clks(Q);

    // 1: write A5 to our address
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'h84, a);
    chk("t1_addr_ack", a, 0);
    chk("t1_busy_on", busy, 1);
    wr_exp_q.push_back(8'hA5);
    write_byte(8'hA5, a);
    chk("t1_data_ack", a, 0);
    i2c_stop();
    wait_clks(4);
    chk("t1_busy_off", busy, 0);
    chk("t1_wr_count", wr_cnt - w0, 1);

    // 2: foreign address is never acknowledged
    w0 = wr_cnt; oe_seen = 1'b0; busy_seen = 1'b0;
    i2c_start();
    write_byte(8'h86, a);
    chk("t2_addr_nack", a, 1);
    write_byte(8'h11, a);
    chk("t2_data_nack", a, 1);
    i2c_stop();
    wait_clks(4);
    chk("t2_sda_oe_never", oe_seen, 0);
    chk("t2_busy_never", busy_seen, 0);
    chk("t2_wr_count", wr_cnt - w0, 0);

    // 3: two-byte read, ACK then NACK
    r0 = rd_cnt;
    txq.push_back(8'h3C); txq.push_back(8'hC3);
    i2c_start();
    write_byte(8'h85, a);
    chk("t3_addr_ack", a, 0);
    read_byte(1'b0, b);
    rd_check("t3_rd0", b);
    read_byte(1'b1, b);
    rd_check("t3_rd1", b);
    wait_clks(2);
    chk("t3_release_after_nack", sda_oe, 0);
    chk("t3_rd_req_count", rd_cnt - r0, 2);
    i2c_stop();
    wait_clks(4);
    chk("t3_busy_off", busy, 0);

    // 4: partial write byte aborted by repeated START, then a read
    w0 = wr_cnt; r0 = rd_cnt;
    txq.push_back(8'h5A);
    i2c_start();
    write_byte(8'h84, a);
    chk("t4_addr_ack", a, 0);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, a);
    i2c_start();
    chk("t4_busy_rs", busy, 0);
    write_byte(8'h85, a);
    chk("t4_rd_addr_ack", a, 0);
    read_byte(1'b1, b);
    rd_check("t4_rd", b);
    i2c_stop();
    wait_clks(4);
    chk("t4_wr_count", wr_cnt - w0, 0);
    chk("t4_rd_req_count", rd_cnt - r0, 1);

    // 5: reset while the target is driving a read bit low
    txq.push_back(8'h00);
    i2c_start();
    write_byte(8'h85, a);
    chk("t5_addr_ack", a, 0);
    clk_bit(1'b1, a);
    clk_bit(1'b1, a);
    n = 0;
    while (!sda_oe && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_driving", sda_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_sda_oe", sda_oe, 0);
    chk("t5_busy", busy, 0);
    chk("t5_state", {29'h0, dut.state_q}, 0);
    scl_drv = 1'b1; sda_drv = 1'b1;
    wait_clks(Q);
    rst = 1'b0;
    rd_exp_q.delete();
    wait_clks(Q);

`ifdef I2C_CLK_STRETCH_EN
    // 6: local data arrives late; SCL held low until it does
    stretch_seen = 1'b0; tx_delay = 50;
    txq.push_back(8'hA7);
    i2c_start();
    write_byte(8'h85, a);
    chk("t6_addr_ack", a, 0);
    read_byte(1'b1, b);
    rd_check("t6_rd", b);
    chk("t6_stretched", stretch_seen, 1);
    i2c_stop();
    wait_clks(4);
    chk("t6_scl_oe_off", scl_oe, 0);
    tx_delay = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
